// File: rtl/pitch_pkg.sv
// rtl/pitch_pkg.sv - shared pitch types, FSM state encoding and helpers
package pitch_pkg;

  localparam int PITCH_WIDTH = 24;

  typedef logic [PITCH_WIDTH-1:0] pitch_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SORT,
    ST_DECIDE,
    ST_EMIT
  } state_t;

  function automatic pitch_t abs_diff(pitch_t a, pitch_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/median_sorter.sv
// rtl/median_sorter.sv - odd-even transposition sorter, one pass per cycle
module median_sorter
  import pitch_pkg::*;
#(
  parameter int WINDOW = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  pitch_t [WINDOW-1:0]     load_i,
  output logic                    done_o,
  output pitch_t                  median_o
);

  pitch_t [WINDOW-1:0] arr_q;
  pitch_t [WINDOW-1:0] arr_d;
  logic   [3:0]        pass_q;
  logic                busy_q;

  // Even passes swap pairs starting at 0, odd passes pairs starting at 1.
  always_comb begin
    arr_d = arr_q;
    for (int i = 0; i < WINDOW - 1; i++) begin
      if ((i % 2) == int'(pass_q[0])) begin
        if (arr_q[i] > arr_q[i+1]) begin
          arr_d[i]   = arr_q[i+1];
          arr_d[i+1] = arr_q[i];
        end
      end
    end
  end

  assign done_o   = busy_q && (pass_q == 4'(WINDOW - 1));
  assign median_o = arr_q[WINDOW/2];

  always_ff @(posedge clk) begin
    if (reset) begin
      arr_q  <= '0;
      pass_q <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      arr_q  <= load_i;
      pass_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      arr_q  <= arr_d;
      pass_q <= pass_q + 4'd1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pitch_tracker.sv
// rtl/pitch_tracker.sv - median + hysteresis pitch tracker; PITCH_TRACKER_DBG_EN adds debug ports
module pitch_tracker
  import pitch_pkg::*;
#(
  parameter int     WINDOW       = 5,
  parameter pitch_t HYST         = 24'd4,
  parameter int     UNVOICED_RUN = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  pitch_t pitch_in_tdata_i,
  input  logic   pitch_in_tvalid_i,
  output logic   pitch_in_tready_o,
  output pitch_t pitch_out_tdata_o,
  output logic   pitch_out_tvalid_o,
  input  logic   pitch_out_tready_i
`ifdef PITCH_TRACKER_DBG_EN
  ,
  output pitch_t      dbg_median_o,
  output logic [15:0] dbg_update_count_o
`endif
);

  localparam logic [3:0] FILL_MAX = 4'(WINDOW);
  localparam logic [7:0] ZR_MAX   = 8'(UNVOICED_RUN);

  state_t              state_q;
  logic                ready_q;
  logic                valid_q;
  pitch_t              data_q;
  pitch_t              held_q;
  pitch_t              held_d;
  pitch_t [WINDOW-1:0] window_q;
  pitch_t [WINDOW-1:0] win_shift;
  logic   [3:0]        fill_q;
  logic   [7:0]        zero_run_q;
  logic                accept;
  logic                unvoiced;
  logic                sort_done;
  pitch_t              median;

  assign accept             = (state_q == ST_IDLE) && ready_q && pitch_in_tvalid_i;
  assign unvoiced           = (zero_run_q == ZR_MAX);
  assign pitch_in_tready_o  = ready_q;
  assign pitch_out_tvalid_o = valid_q;
  assign pitch_out_tdata_o  = data_q;

  // Newest sample enters at index 0; the oldest falls off the top.
  always_comb begin
    win_shift    = window_q << PITCH_WIDTH;
    win_shift[0] = pitch_in_tdata_i;
  end

  median_sorter #(
    .WINDOW(WINDOW)
  ) u_sorter (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept),
    .load_i   (win_shift),
    .done_o   (sort_done),
    .median_o (median)
  );

  always_comb begin
    held_d = held_q;
    if (unvoiced) begin
      held_d = '0;
    end else if (fill_q < FILL_MAX) begin
      held_d = '0;
    end else if ((held_q == '0) && (median != '0)) begin
      held_d = median;
    end else if (abs_diff(median, held_q) > HYST) begin
      held_d = median;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      held_q     <= '0;
      window_q   <= '0;
      fill_q     <= '0;
      zero_run_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            window_q   <= win_shift;
            fill_q     <= (fill_q == FILL_MAX) ? fill_q : fill_q + 4'd1;
            if (pitch_in_tdata_i == '0) begin
              zero_run_q <= (zero_run_q == ZR_MAX) ? zero_run_q : zero_run_q + 8'd1;
            end else begin
              zero_run_q <= '0;
            end
            ready_q <= 1'b0;
            state_q <= ST_SORT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SORT: begin
          if (sort_done) begin
            state_q <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          held_q  <= held_d;
          data_q  <= held_d;
          valid_q <= 1'b1;
          if (unvoiced) begin
            window_q <= '0;
            fill_q   <= '0;
          end
          state_q <= ST_EMIT;
        end
        ST_EMIT: begin
          if (pitch_out_tready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PITCH_TRACKER_DBG_EN
  pitch_t      dbg_median_q;
  logic [15:0] dbg_update_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_median_q       <= '0;
      dbg_update_count_q <= '0;
    end else if (state_q == ST_DECIDE) begin
      dbg_median_q <= median;
      if (held_d != held_q) begin
        dbg_update_count_q <= dbg_update_count_q + 16'd1;
      end
    end
  end

  assign dbg_median_o       = dbg_median_q;
  assign dbg_update_count_o = dbg_update_count_q;
`endif

endmodule
